// File: rtl/ledflow_pkg.sv
// Shared constants for the LED flowing-light engine: pattern modes, bounce
// direction encoding and a width helper for the prescaler counter.
package ledflow_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // A period of one cycle still needs a 1-bit counter to keep ports legal.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc <= 1) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/ledflow_prescaler.sv
// Step-period prescaler: counts up to a speed-dependent terminal value and
// emits a single-cycle step request while not paused.
module ledflow_prescaler
  import ledflow_pkg::*;
#(
  parameter int unsigned STEP_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       step
);

  localparam int unsigned CW = cnt_width(STEP_CYC);

  localparam int unsigned P0 = STEP_CYC;
  localparam int unsigned P1 = STEP_CYC >> 1;
  localparam int unsigned P2 = STEP_CYC >> 2;
  localparam int unsigned P3 = STEP_CYC >> 3;

  // Terminal counts clamp at zero so very short periods degrade to every cycle.
  localparam int unsigned T0 = (P0 > 0) ? P0 - 1 : 0;
  localparam int unsigned T1 = (P1 > 0) ? P1 - 1 : 0;
  localparam int unsigned T2 = (P2 > 0) ? P2 - 1 : 0;
  localparam int unsigned T3 = (P3 > 0) ? P3 - 1 : 0;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] term;

  always_comb begin
    case (speed)
      2'd0:    term = CW'(T0);
      2'd1:    term = CW'(T1);
      2'd2:    term = CW'(T2);
      default: term = CW'(T3);
    endcase
  end

  // A count already past a freshly lowered terminal value also steps.
  assign step = !pause && (cnt_q >= term);

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = '0;
    end else if (!pause) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ledflow_ctrl.sv
// LED pattern engine: rotate left/right, bounce and blink patterns stepped by
// a speed-selectable prescaler, with pause and selectable output polarity.
module ledflow_ctrl
  import ledflow_pkg::*;
#(
  parameter int unsigned N_LED      = 4,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned STEP_MS    = 500,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int unsigned STEP_CYC = CLK_HZ / 1000 * STEP_MS;
  localparam int unsigned PW       = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [PW-1:0] LAST   = PW'(N_LED - 1);

  logic          step;
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic          tick_q;
  logic [N_LED-1:0] pat;

  ledflow_prescaler #(
    .STEP_CYC (STEP_CYC)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .speed (speed),
    .pause (pause),
    .step  (step)
  );

  // The incoming mode is applied to the current pos/dir; position is never re-homed.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    if (step) begin
      mode_d = mode;
      case (mode)
        MODE_ROT_L: begin
          pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
        end
        MODE_ROT_R: begin
          pos_d = (pos_q == '0) ? LAST : pos_q - PW'(1);
        end
        MODE_BOUNCE: begin
          if (N_LED == 1) begin
            pos_d = '0;
          end else if (dir_q == DIR_UP) begin
            if (pos_q == LAST) begin
              dir_d = DIR_DN;
              pos_d = pos_q - PW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = pos_q + PW'(1);
            end else begin
              pos_d = pos_q - PW'(1);
            end
          end
        end
        MODE_BLINK: begin
          phase_d = ~phase_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      phase_q <= 1'b0;
      mode_q  <= MODE_ROT_L;
      tick_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      tick_q  <= step;
    end
  end

  always_comb begin
    pat = '0;
    if (mode_q == MODE_BLINK) begin
      pat = {N_LED{phase_q}};
    end else begin
      for (int i = 0; i < int'(N_LED); i++) begin
        pat[i] = (pos_q == PW'(i));
      end
    end
  end

  assign led  = ACTIVE_LOW ? ~pat : pat;
  // Masking with pause keeps tick low even in the cycle pause is raised.
  assign tick = tick_q & ~pause;

endmodule
